// File: rtl/hash_table_arbiter.sv
// hash_table_arbiter
//   Shares one hash-table command/response port between NUM_REQ requesters.
//   A round-robin arbiter loads a single registered command slot toward the
//   table. Every granted requester ID is pushed into an in-order FIFO, and the
//   head of that FIFO steers each response back to the requester that issued it.
//   The table must answer commands in the order it received them.
//
// Ports
//   clk, reset        single clock; reset is asynchronous and active-high
//   req_valid_i       per-requester command valid
//   req_data_i        packed commands, requester r at [r*CMD_W +: CMD_W]
//   req_ready_o       one-hot grant (command accepted on valid & ready)
//   tbl_valid_o/data  registered command toward the table
//   tbl_ready_i       table accepts the command
//   tbl_rsp_*         response from the table and its ready
//   rsp_valid_o       one-hot response valid to the owning requester
//   rsp_data_o        table response data, shared by all requesters
//   rsp_ready_i       per-requester response ready
//   outstanding_o     commands issued whose response has not been popped yet
//   err_unexp_rsp_o   sticky flag: a response arrived while no ID was pending
module hash_table_arbiter #(
    parameter int KEY_WIDTH       = 5,
    parameter int DATA_WIDTH      = 25,
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CMD_W = 2 + DATA_WIDTH + KEY_WIDTH,
    localparam int IDW   = $clog2(NUM_REQ),
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*CMD_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     tbl_valid_o,
    output logic [CMD_W-1:0]         tbl_data_o,
    input  logic                     tbl_ready_i,
    input  logic                     tbl_rsp_valid_i,
    input  logic [31:0]              tbl_rsp_data_i,
    output logic                     tbl_rsp_ready_o,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    output logic [31:0]              rsp_data_o,
    input  logic [NUM_REQ-1:0]       rsp_ready_i,
    output logic [CW-1:0]            outstanding_o,
    output logic                     err_unexp_rsp_o
);

    localparam int PW = $clog2(MAX_OUTSTANDING);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] head;
    logic           grant_any;
    logic           can_load;
    logic           push;
    logic           pop;
    logic           empty;

    logic [IDW-1:0] id_mem [MAX_OUTSTANDING];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    // The slot can take a new command when it is empty or draining this cycle,
    // and only while the registered count leaves room in the ID FIFO. Reset
    // gating keeps req_ready_o low while reset is held.
    assign can_load = !reset && (!tbl_valid_o || tbl_ready_i)
                      && (outstanding_o < CW'(MAX_OUTSTANDING));

    // Round-robin search: the first valid requester starting from ptr, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        if (can_load) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = IDW'((int'(ptr) + i) % NUM_REQ);
                if (!grant_any && req_valid_i[cand]) begin
                    grant_any = 1'b1;
                    grant_id  = cand;
                end
            end
        end
    end

    assign req_ready_o = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
    assign push        = grant_any;
    assign empty       = (outstanding_o == '0);
    assign head        = id_mem[rd_ptr];

    // Steer the response to the requester at the head of the ID FIFO.
    always_comb begin
        rsp_valid_o     = '0;
        tbl_rsp_ready_o = 1'b0;
        if (!empty) begin
            rsp_valid_o[head] = tbl_rsp_valid_i;
            tbl_rsp_ready_o   = rsp_ready_i[head];
        end
    end

    assign rsp_data_o = tbl_rsp_data_i;
    assign pop        = tbl_rsp_valid_i && tbl_rsp_ready_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl_valid_o     <= 1'b0;
            tbl_data_o      <= '0;
            ptr             <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            outstanding_o   <= '0;
            err_unexp_rsp_o <= 1'b0;
        end else begin
            if (push) begin
                tbl_valid_o <= 1'b1;
                tbl_data_o  <= req_data_i[int'(grant_id)*CMD_W +: CMD_W];
                ptr         <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end else if (tbl_ready_i) begin
                tbl_valid_o <= 1'b0;
            end

            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            // Push and pop together leave the count unchanged.
            case ({push, pop})
                2'b10:   outstanding_o <= outstanding_o + 1'b1;
                2'b01:   outstanding_o <= outstanding_o - 1'b1;
                default: outstanding_o <= outstanding_o;
            endcase

            if (tbl_rsp_valid_i && empty)
                err_unexp_rsp_o <= 1'b1;
        end
    end

    // ID storage needs no reset: entries are only read while the count is non-zero.
    always_ff @(posedge clk) begin
        if (push)
            id_mem[wr_ptr] <= grant_id;
    end

endmodule

// File: tb/tb_hash_table_arbiter.sv
module tb_hash_table_arbiter;

    localparam logic [31:0] C0 = 32'h5400_0123; // {op=1,key=0x0A,data=0x123}
    localparam logic [31:0] C1 = 32'h8123_4567;
    localparam logic [31:0] C2 = 32'hC2AA_0F0F;
    localparam logic [31:0] C3 = 32'h3FFF_FFFE;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid_i;
    logic [127:0] req_data_i;
    logic [3:0]  req_ready_o;
    logic        tbl_valid_o;
    logic [31:0] tbl_data_o;
    logic        tbl_ready_i;
    logic        tbl_rsp_valid_i;
    logic [31:0] tbl_rsp_data_i;
    logic        tbl_rsp_ready_o;
    logic [3:0]  rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic [3:0]  rsp_ready_i;
    logic [2:0]  outstanding_o;
    logic        err_unexp_rsp_o;

    always #5 clk = ~clk;

    hash_table_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .tbl_valid_o     (tbl_valid_o),
        .tbl_data_o      (tbl_data_o),
        .tbl_ready_i     (tbl_ready_i),
        .tbl_rsp_valid_i (tbl_rsp_valid_i),
        .tbl_rsp_data_i  (tbl_rsp_data_i),
        .tbl_rsp_ready_o (tbl_rsp_ready_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_data_o      (rsp_data_o),
        .rsp_ready_i     (rsp_ready_i),
        .outstanding_o   (outstanding_o),
        .err_unexp_rsp_o (err_unexp_rsp_o)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic        tr;
        logic        trv;
        logic [31:0] rd;
        logic [3:0]  rr;
        logic [3:0]  e_rdy;
        logic        e_tv;
        logic [31:0] e_td;
        logic [2:0]  e_out;
        logic [3:0]  e_rspv;
        logic        e_trr;
        logic        e_err;
    } vec_t;

    vec_t tab[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic rst, input logic [3:0] rv, input logic tr,
                                input logic trv, input logic [31:0] rd, input logic [3:0] rr,
                                input logic [3:0] e_rdy, input logic e_tv, input logic [31:0] e_td,
                                input logic [2:0] e_out, input logic [3:0] e_rspv,
                                input logic e_trr, input logic e_err);
        vec_t v;
        v.rst = rst; v.rv = rv; v.tr = tr; v.trv = trv; v.rd = rd; v.rr = rr;
        v.e_rdy = e_rdy; v.e_tv = e_tv; v.e_td = e_td; v.e_out = e_out;
        v.e_rspv = e_rspv; v.e_trr = e_trr; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] rv, input logic tr,
                         input logic trv, input logic [31:0] rd, input logic [3:0] rr);
        reset           = rst;
        req_valid_i     = rv;
        tbl_ready_i     = tr;
        tbl_rsp_valid_i = trv;
        tbl_rsp_data_i  = rd;
        rsp_ready_i     = rr;
    endtask

    // Entered one time unit after a rising edge; checks mid-cycle, returns after the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input vec_t v, input int idx);
        drive(v.rst, v.rv, v.tr, v.trv, v.rd, v.rr);
        #4;
        chk($sformatf("v%0d req_ready", idx), 32'(req_ready_o), 32'(v.e_rdy));
        chk($sformatf("v%0d tbl_valid", idx), 32'(tbl_valid_o), 32'(v.e_tv));
        if (v.e_tv)
            chk($sformatf("v%0d tbl_data", idx), tbl_data_o, v.e_td);
        chk($sformatf("v%0d outstanding", idx), 32'(outstanding_o), 32'(v.e_out));
        chk($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid_o), 32'(v.e_rspv));
        chk($sformatf("v%0d tbl_rsp_ready", idx), 32'(tbl_rsp_ready_o), 32'(v.e_trr));
        chk($sformatf("v%0d err", idx), 32'(err_unexp_rsp_o), 32'(v.e_err));
        chk($sformatf("v%0d rsp_data", idx), rsp_data_o, v.rd);
        tick();
    endtask

    initial begin
        req_data_i = {C3, C2, C1, C0};
        drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0);

        //    rst rv  tr trv rd      rr   | rdy tv td  out rspv trr err
        // single request from requester 0, then its response
        tab.push_back(mk(0, 4'h1, 1, 0, 32'h0,   4'h0, 4'h1, 0, 32'h0, 0, 4'h0, 0, 0));
        tab.push_back(mk(0, 4'h0, 1, 0, 32'h0,   4'h0, 4'h0, 1, C0,    1, 4'h0, 0, 0));
        tab.push_back(mk(0, 4'h0, 1, 1, 32'h123, 4'h1, 4'h0, 0, 32'h0, 1, 4'h1, 1, 0));
        tab.push_back(mk(0, 4'h0, 1, 0, 32'h0,   4'h0, 4'h0, 0, 32'h0, 0, 4'h0, 0, 0));
        // reset held with all requesters valid: no grant while in reset
        tab.push_back(mk(1, 4'hF, 1, 0, 32'h0,   4'h0, 4'h0, 0, 32'h0, 0, 4'h0, 0, 0));
        // all four valid every cycle: grants 0,1,2,3 then blocked at 4 outstanding
        tab.push_back(mk(0, 4'hF, 1, 0, 32'h0,   4'h0, 4'h1, 0, 32'h0, 0, 4'h0, 0, 0));
        tab.push_back(mk(0, 4'hF, 1, 0, 32'h0,   4'h0, 4'h2, 1, C0,    1, 4'h0, 0, 0));
        tab.push_back(mk(0, 4'hF, 1, 0, 32'h0,   4'h0, 4'h4, 1, C1,    2, 4'h0, 0, 0));
        tab.push_back(mk(0, 4'hF, 1, 0, 32'h0,   4'h0, 4'h8, 1, C2,    3, 4'h0, 0, 0));
        tab.push_back(mk(0, 4'hF, 1, 0, 32'h0,   4'h0, 4'h0, 1, C3,    4, 4'h0, 0, 0));
        tab.push_back(mk(0, 4'hF, 1, 0, 32'h0,   4'h0, 4'h0, 0, 32'h0, 4, 4'h0, 0, 0));
        // responses in order; a pop while full does not free a slot in that cycle
        tab.push_back(mk(0, 4'hF, 1, 1, 32'hA,   4'hF, 4'h0, 0, 32'h0, 4, 4'h1, 1, 0));
        tab.push_back(mk(0, 4'h0, 1, 1, 32'hB,   4'hF, 4'h0, 0, 32'h0, 3, 4'h2, 1, 0));
        tab.push_back(mk(0, 4'h0, 1, 1, 32'hC,   4'hF, 4'h0, 0, 32'h0, 2, 4'h4, 1, 0));
        tab.push_back(mk(0, 4'h0, 1, 1, 32'hD,   4'hF, 4'h0, 0, 32'h0, 1, 4'h8, 1, 0));
        tab.push_back(mk(0, 4'h0, 1, 0, 32'h0,   4'hF, 4'h0, 0, 32'h0, 0, 4'h0, 0, 0));
        // simultaneous push and pop keep the count at 1; pointer wrap 2->3->0
        tab.push_back(mk(0, 4'h2, 1, 0, 32'h0,   4'h0, 4'h2, 0, 32'h0, 0, 4'h0, 0, 0));
        tab.push_back(mk(0, 4'h1, 1, 1, 32'h55,  4'h2, 4'h1, 1, C1,    1, 4'h2, 1, 0));
        tab.push_back(mk(0, 4'h0, 1, 0, 32'h0,   4'h0, 4'h0, 1, C0,    1, 4'h0, 0, 0));
        tab.push_back(mk(0, 4'h0, 1, 1, 32'h77,  4'h1, 4'h0, 0, 32'h0, 1, 4'h1, 1, 0));
        // requester 2 response held off for 3 cycles
        tab.push_back(mk(0, 4'h4, 1, 0, 32'h0,   4'h0, 4'h4, 0, 32'h0, 0, 4'h0, 0, 0));
        tab.push_back(mk(0, 4'h0, 1, 1, 32'h99,  4'hB, 4'h0, 1, C2,    1, 4'h4, 0, 0));
        tab.push_back(mk(0, 4'h0, 1, 1, 32'h99,  4'hB, 4'h0, 0, 32'h0, 1, 4'h4, 0, 0));
        tab.push_back(mk(0, 4'h0, 1, 1, 32'h99,  4'hB, 4'h0, 0, 32'h0, 1, 4'h4, 0, 0));
        tab.push_back(mk(0, 4'h0, 1, 1, 32'h99,  4'h4, 4'h0, 0, 32'h0, 1, 4'h4, 1, 0));
        tab.push_back(mk(0, 4'h0, 1, 0, 32'h0,   4'h0, 4'h0, 0, 32'h0, 0, 4'h0, 0, 0));

        // reset state
        tick();
        chk("reset tbl_valid",   32'(tbl_valid_o),     32'h0);
        chk("reset tbl_data",    tbl_data_o,           32'h0);
        chk("reset outstanding", 32'(outstanding_o),   32'h0);
        chk("reset err",         32'(err_unexp_rsp_o), 32'h0);
        chk("reset req_ready",   32'(req_ready_o),     32'h0);
        chk("reset rsp_valid",   32'(rsp_valid_o),     32'h0);

        foreach (tab[i]) step(tab[i], i);

        // table stall: pointer is at 3 here
        drive(0, 4'h8, 0, 0, 32'h0, 4'h0);
        #4 chk("stall grant3", 32'(req_ready_o), 32'h8);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(0, 4'hF, 0, 0, 32'h0, 4'h0);
            #4;
            chk($sformatf("stall%0d req_ready", k), 32'(req_ready_o), 32'h0);
            chk($sformatf("stall%0d tbl_valid", k), 32'(tbl_valid_o), 32'h1);
            chk($sformatf("stall%0d tbl_data",  k), tbl_data_o,       C3);
            tick();
        end
        drive(0, 4'h0, 1, 0, 32'h0, 4'h0);
        #4 chk("accept tbl_valid", 32'(tbl_valid_o), 32'h1);
        tick();
        #4 chk("after accept tbl_valid", 32'(tbl_valid_o), 32'h0);
        chk("after accept outstanding", 32'(outstanding_o), 32'h1);
        tick();

        // reset drops the pending ID
        drive(1, 4'h0, 1, 0, 32'h0, 4'h0);
        #4 chk("rst2 outstanding", 32'(outstanding_o), 32'h0);
        tick();

        // unexpected response with nothing issued
        drive(0, 4'h0, 1, 1, 32'hDEAD, 4'hF);
        #4;
        chk("unexp rsp_valid",     32'(rsp_valid_o),     32'h0);
        chk("unexp tbl_rsp_ready", 32'(tbl_rsp_ready_o), 32'h0);
        chk("unexp err before",    32'(err_unexp_rsp_o), 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, (k == 0) ? 4'h1 : 4'h0, 1, 0, 32'h0, 4'h0);
            #4 chk($sformatf("sticky%0d err", k), 32'(err_unexp_rsp_o), 32'h1);
            tick();
        end

        // reset mid-stream with a command pending and requesters still valid
        drive(1, 4'hF, 1, 0, 32'h0, 4'h0);
        #4;
        chk("rst3 err",         32'(err_unexp_rsp_o), 32'h0);
        chk("rst3 tbl_valid",   32'(tbl_valid_o),     32'h0);
        chk("rst3 tbl_data",    tbl_data_o,           32'h0);
        chk("rst3 outstanding", 32'(outstanding_o),   32'h0);
        chk("rst3 req_ready",   32'(req_ready_o),     32'h0);
        tick();
        drive(0, 4'h0, 1, 0, 32'h0, 4'h0);
        #4 chk("post rst3 err", 32'(err_unexp_rsp_o), 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
